tmr_prescaled: RTL and testbench

Parametrised successor to the PIC timer-0 block: a WIDTH-bit up-counter with a programmable power-of-two prescaler. It counts either instruction cycles or synchronised edges of an external pin, and supports free-running or period-reload modes. It sits in the peripheral space next to the core, which reads and writes the counter and consumes the single-cycle overflow pulse to set the interrupt flag. Everything runs in the `clkout` domain. The external input is synchronised internally, so there is no second clock.

---
 rtl/tmr_prescaled.sv | 108 ++++++++++
 tb/tb_tmr_prescaled.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_prescaled.sv
// WIDTH-bit timer with power-of-two prescaler, internal or synchronised external source, free-run or period reload.
// Latency: 1 cycle from write to tmr_out, 3 clkout edges from an ext_clk transition to a count; no backpressure.
module tmr_prescaled #(
  parameter int WIDTH   = 8,
  parameter int PS_BITS = 3
) (
  input  logic               clkout,
  input  logic               rst,
  input  logic               en,
  input  logic               cs,
  input  logic               ext_clk,
  input  logic               se,
  input  logic               psa,
  input  logic [PS_BITS-1:0] ps,
  input  logic               mode,
  input  logic [WIDTH-1:0]   period,
  input  logic               tmr_wr_en,
  input  logic [WIDTH-1:0]   tmr_wr_data,
  output logic [WIDTH-1:0]   tmr_out,
  output logic               ovf_pulse
);

  localparam int PRE_W = 1 << PS_BITS;
  localparam logic [WIDTH-1:0] TMR_ONE = WIDTH'(1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic               s1, s2, prev;
  logic [PRE_W-1:0]   pre;
  logic [PRE_W-1:0]   pre_mask;
  logic [PS_BITS-1:0] ps_q;
  logic               psa_q;
  logic [1:0]         inhibit;
  logic               rise, fall, sel_edge, tick;
  logic               pre_full, pre_clr, inc, inc_ok, wrap;
  logic [WIDTH-1:0]   tmr_nxt;

  always_comb begin
    rise     = s2 & ~prev;
    fall     = ~s2 & prev;
    sel_edge = se ? fall : rise;
    tick     = en & (cs ? sel_edge : 1'b1);

    pre_mask = '0;
    for (int i = 0; i < PRE_W; i++) begin
      pre_mask[i] = (i <= int'(ps));
    end
    pre_full = ((pre & pre_mask) == pre_mask);
    inc      = tick & (psa | pre_full);
    pre_clr  = tmr_wr_en | (ps != ps_q) | (psa != psa_q);

    // A load owns the counter for its own cycle and the two that follow.
    inc_ok   = inc & ~tmr_wr_en & (inhibit == 2'd0);

    // Reaching period reloads; all-ones always wraps, which recovers tmr > period.
    wrap     = (tmr_out == '1) | (mode & (tmr_out == period));
    tmr_nxt  = wrap ? '0 : tmr_out + TMR_ONE;
  end

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= ext_clk;
      s2   <= s1;
      prev <= s2;
    end
  end

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      pre   <= '0;
      ps_q  <= '0;
      psa_q <= 1'b0;
    end else begin
      ps_q  <= ps;
      psa_q <= psa;
      if (pre_clr || psa) begin
        pre <= '0;
      end else if (tick) begin
        pre <= pre + PRE_ONE;
      end
    end
  end

  always_ff @(posedge clkout or negedge rst) begin
    if (!rst) begin
      tmr_out   <= '0;
      ovf_pulse <= 1'b0;
      inhibit   <= 2'd0;
    end else if (tmr_wr_en) begin
      tmr_out   <= tmr_wr_data;
      ovf_pulse <= 1'b0;
      inhibit   <= 2'd2;
    end else begin
      ovf_pulse <= 1'b0;
      if (inhibit != 2'd0) begin
        inhibit <= inhibit - 2'd1;
      end
      if (inc_ok) begin
        tmr_out   <= tmr_nxt;
        ovf_pulse <= wrap;
      end
    end
  end

endmodule

// File: tb/tb_tmr_prescaled.sv
// Bench for tmr_prescaled: directed vector table, hand sequences for multi-cycle corners, random run against a reference model.
module tb_tmr_prescaled;

  localparam int W     = 8;
  localparam int PSB   = 3;
  localparam int TMAX  = (1 << W) - 1;
  localparam int PMOD  = 1 << (1 << PSB);

  logic           clkout = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0, cs = 1'b0, ext_clk = 1'b0, se = 1'b0, psa = 1'b1, mode = 1'b0;
  logic [PSB-1:0] ps = '0;
  logic [W-1:0]   period = '0;
  logic           tmr_wr_en = 1'b0;
  logic [W-1:0]   tmr_wr_data = '0;
  logic [W-1:0]   tmr_out;
  logic           ovf_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  tmr_prescaled #(.WIDTH(W), .PS_BITS(PSB)) dut (
    .clkout(clkout), .rst(rst), .en(en), .cs(cs), .ext_clk(ext_clk), .se(se),
    .psa(psa), .ps(ps), .mode(mode), .period(period),
    .tmr_wr_en(tmr_wr_en), .tmr_wr_data(tmr_wr_data),
    .tmr_out(tmr_out), .ovf_pulse(ovf_pulse)
  );

  always #5 clkout = ~clkout;

  // Reference model: state kept as plain integers, advanced once per clkout edge.
  int m_tmr, m_pre, m_inh, m_ps_q;
  bit m_ovf, m_psa_q, m_s1, m_s2, m_prev;

  function automatic void model_reset();
    m_tmr = 0; m_pre = 0; m_inh = 0; m_ps_q = 0;
    m_ovf = 0; m_psa_q = 0; m_s1 = 0; m_s2 = 0; m_prev = 0;
  endfunction

  function automatic void model_step();
    bit rise, fall, edg, tick, clr, inc, hon;
    int ratio;
    rise  = m_s2 && !m_prev;
    fall  = !m_s2 && m_prev;
    edg   = se ? fall : rise;
    tick  = en && (cs ? edg : 1'b1);
    clr   = tmr_wr_en || (int'(ps) != m_ps_q) || (psa != m_psa_q);
    ratio = 1 << (int'(ps) + 1);
    inc   = tick && (psa || (m_pre % ratio == ratio - 1));
    hon   = inc && !tmr_wr_en && (m_inh == 0);
    m_ovf = 0;
    if (tmr_wr_en) begin
      m_tmr = int'(tmr_wr_data);
      m_inh = 2;
    end else begin
      if (m_inh > 0) m_inh--;
      if (hon) begin
        if ((mode && m_tmr == int'(period)) || m_tmr == TMAX) begin
          m_tmr = 0;
          m_ovf = 1;
        end else begin
          m_tmr++;
        end
      end
    end
    if (clr || psa) m_pre = 0;
    else if (tick) m_pre = (m_pre + 1) % PMOD;
    m_ps_q  = int'(ps);
    m_psa_q = psa;
    m_prev  = m_s2;
    m_s2    = m_s1;
    m_s1    = ext_clk;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one edge (model in lockstep), land on the following falling edge.
  task automatic step();
    @(posedge clkout);
    model_step();
    @(negedge clkout);
  endtask

  task automatic cmp(input string nm);
    chk({nm, "_tmr"}, int'(tmr_out), m_tmr);
    chk({nm, "_ovf"}, int'(ovf_pulse), int'(m_ovf));
  endtask

  typedef struct {
    bit       wr;
    bit [7:0] data;
    bit       md;
    bit [7:0] per;
    bit [7:0] exp_tmr;
    bit       exp_ovf;
  } vec_t;

  function automatic vec_t mk(bit wr, int data, bit md, int per, int et, bit eo);
    vec_t v;
    v.wr = wr; v.data = 8'(data); v.md = md; v.per = 8'(per);
    v.exp_tmr = 8'(et); v.exp_ovf = eo;
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   base;
    bit   hit;

    // Free-run write/inhibit, write of 0, period 5, write above period, period 0.
    tbl.push_back(mk(1, 'hFE, 0, 0, 'hFE, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'hFE, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'hFE, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'hFF, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 1));
    tbl.push_back(mk(0, 0, 0, 0, 'h01, 0));
    tbl.push_back(mk(1, 0, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 'h01, 0));
    tbl.push_back(mk(1, 0, 1, 5, 'h00, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'h00, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'h00, 0));
    for (int k = 1; k <= 5; k++) tbl.push_back(mk(0, 0, 1, 5, k, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'h00, 1));
    tbl.push_back(mk(0, 0, 1, 5, 'h01, 0));
    tbl.push_back(mk(1, 'hFE, 1, 5, 'hFE, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'hFE, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'hFE, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'hFF, 0));
    tbl.push_back(mk(0, 0, 1, 5, 'h00, 1));
    tbl.push_back(mk(0, 0, 1, 5, 'h01, 0));
    tbl.push_back(mk(1, 0, 1, 0, 'h00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 'h00, 0));
    tbl.push_back(mk(0, 0, 1, 0, 'h00, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 0, 1, 0, 'h00, 1));

    // Reset held across two edges.
    repeat (2) @(posedge clkout);
    @(negedge clkout);
    chk("reset_tmr", int'(tmr_out), 0);
    chk("reset_ovf", int'(ovf_pulse), 0);

    // Free-run 1:1 through a full wrap.
    en = 1; cs = 0; psa = 1; mode = 0;
    rst = 1;
    model_reset();
    for (int i = 0; i < 256; i++) begin
      step();
      cmp("freerun_model");
      chk("freerun_tmr", int'(tmr_out), (i + 1) % 256);
      chk("freerun_ovf", int'(ovf_pulse), (i == 255) ? 1 : 0);
    end

    // Table-driven vectors.
    foreach (tbl[i]) begin
      tmr_wr_en = tbl[i].wr; tmr_wr_data = tbl[i].data;
      mode = tbl[i].md; period = tbl[i].per;
      step();
      tmr_wr_en = 0;
      chk($sformatf("vec%0d_tmr", i), int'(tmr_out), int'(tbl[i].exp_tmr));
      chk($sformatf("vec%0d_ovf", i), int'(ovf_pulse), int'(tbl[i].exp_ovf));
    end

    // Period mode with a load above period: run to all-ones, wrap, then reload at 5.
    mode = 1; period = 5; tmr_wr_en = 1; tmr_wr_data = 9;
    step();
    tmr_wr_en = 0;
    repeat (248) begin step(); cmp("per_above"); end
    chk("per_above_ff", int'(tmr_out), 'hFF);
    step();
    chk("per_above_wrap_tmr", int'(tmr_out), 0);
    chk("per_above_wrap_ovf", int'(ovf_pulse), 1);
    repeat (5) begin step(); cmp("per_cycle"); end
    chk("per_cycle_5", int'(tmr_out), 5);
    step();
    chk("per_reload_tmr", int'(tmr_out), 0);
    chk("per_reload_ovf", int'(ovf_pulse), 1);

    // Prescaler 1:8, then ps dropped to 0 mid-count.
    mode = 0; psa = 0; ps = 2; tmr_wr_en = 1; tmr_wr_data = 0;
    step();
    tmr_wr_en = 0;
    repeat (7) begin step(); cmp("pre8"); end
    chk("pre8_hold", int'(tmr_out), 0);
    step();
    chk("pre8_first", int'(tmr_out), 1);
    repeat (7) begin step(); cmp("pre8"); end
    chk("pre8_hold2", int'(tmr_out), 1);
    step();
    chk("pre8_second", int'(tmr_out), 2);
    repeat (2) step();
    ps = 0;
    step();
    chk("ps_chg_a", int'(tmr_out), 2);
    step();
    chk("ps_chg_b", int'(tmr_out), 2);
    step();
    chk("ps_chg_inc", int'(tmr_out), 3);
    cmp("ps_chg_model");

    // External source: rising, then falling, then disabled.
    psa = 1; cs = 1; se = 0; ext_clk = 0;
    repeat (4) step();
    for (int ph = 0; ph < 3; ph++) begin
      se = (ph == 1);
      en = (ph != 2);
      for (int t = 0; t < 6; t++) begin
        ext_clk = ~ext_clk;
        base = int'(tmr_out);
        step(); step();
        chk("ext_wait", int'(tmr_out), base);
        step();
        hit = en && ((!se && ext_clk) || (se && !ext_clk));
        chk("ext_count", int'(tmr_out), (base + int'(hit)) % 256);
        step();
        cmp("ext_model");
      end
    end
    en = 1;

    // Random run against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) cs = ~cs;
      if ($urandom_range(0, 2) == 0) ext_clk = ~ext_clk;
      if ($urandom_range(0, 99) == 0) se = ~se;
      if ($urandom_range(0, 59) == 0) psa = ~psa;
      if ($urandom_range(0, 39) == 0) ps = PSB'($urandom_range(0, 2));
      if ($urandom_range(0, 99) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) period = W'($urandom_range(0, 255));
      tmr_wr_en = ($urandom_range(0, 29) == 0);
      tmr_wr_data = W'($urandom_range(0, 255));
      step();
      cmp("rand");
    end
    tmr_wr_en = 0;

    // Asynchronous reset mid-count with a nonzero prescaler.
    en = 1; cs = 0; ext_clk = 0; mode = 0; psa = 0; ps = 7;
    tmr_wr_en = 1; tmr_wr_data = 'h80;
    step();
    tmr_wr_en = 0;
    repeat (5) begin step(); cmp("prerst"); end
    chk("prerst_tmr", int'(tmr_out), 'h80);
    #2 rst = 0;
    #1;
    chk("async_rst_tmr", int'(tmr_out), 0);
    chk("async_rst_ovf", int'(ovf_pulse), 0);
    @(negedge clkout);
    rst = 1;
    psa = 1;
    model_reset();
    step();
    chk("resume_1", int'(tmr_out), 1);
    step();
    chk("resume_2", int'(tmr_out), 2);
    cmp("resume_model");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
